apb_reg_bridge: RTL and testbench

- Parametrised APB4 slave front-end; successor to the fixed 8-bit-address / 32-register APB interface.
- Converts APB4 transfers into a simple register-bank strobe interface: one-hot select, write pulse, byte strobes, read data.
- Adds configurable read latency (wait states), PSTRB byte enables, and PSLVERR for unmapped or misaligned accesses.
- Sits between the APB fabric and each peripheral's register bank.

---
 rtl/apb_bridge_pkg.sv | 33 +++
 rtl/apb_addr_decode.sv | 50 +++++
 rtl/apb_reg_bridge.sv | 161 ++++++++++++++++
 tb/tb_apb_reg_bridge.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/apb_bridge_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : apb_bridge_pkg                                               |
// | Description : Shared types and helpers for the APB4 register bridge:       |
// |               FSM state encoding, ceil-log2 helper, and the maximum read   |
// |               latency the wait-state counter is sized for.                 |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
package apb_bridge_pkg;

    // Largest register-bank read latency the wait-state counter can hold.
    localparam int RD_LAT_MAX = 7;

    // Bridge FSM states, explicitly 2 bits wide.
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        WR     = 2'd1,
        RDWAIT = 2'd2,
        RESP   = 2'd3
    } bridgeState_t;

    // Ceiling log2; clog2(1) = 0.
    function automatic int clog2(input int value);
        int result;
        result = 0;
        while ((1 << result) < value) begin
            result++;
        end
        return result;
    endfunction

endpackage
`default_nettype wire

// File: rtl/apb_addr_decode.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : apb_addr_decode                                              |
// | Description : Combinational APB byte-address decoder. Converts a byte      |
// |               address into a word index, a one-hot register select and a   |
// |               valid flag (index in range and address word-aligned).        |
// | Ports       : iPAddr [AW]        byte address                              |
// |               oIdx   [AW-log2(DW/8)] word index                            |
// |               oSel   [NREG]      one-hot select, all-zero when invalid     |
// |               oValid             address maps to an existing register      |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module apb_addr_decode
    import apb_bridge_pkg::*;
#(
    parameter int AW   = 8,
    parameter int DW   = 32,
    parameter int NREG = 32
)
(
    input  logic [AW-1:0]               iPAddr,
    output logic [AW-clog2(DW/8)-1:0]   oIdx,
    output logic [NREG-1:0]             oSel,
    output logic                        oValid
);

    localparam int              c_OFFW = clog2(DW / 8);
    localparam logic [31:0]     c_NREG = NREG;
    localparam logic [NREG-1:0] c_ONE  = NREG'(1);

    logic w_inRange;
    logic w_aligned;

    assign oIdx      = iPAddr[AW-1:c_OFFW];
    assign w_inRange = (32'(oIdx) < c_NREG);

    // With an 8-bit data path every byte address is a word address.
    generate
        if (c_OFFW > 0) begin : g_alignChk
            assign w_aligned = (iPAddr[c_OFFW-1:0] == '0);
        end else begin : g_noAlignChk
            assign w_aligned = 1'b1;
        end
    endgenerate

    assign oValid = w_inRange && w_aligned;
    assign oSel   = oValid ? (c_ONE << oIdx) : '0;

endmodule
`default_nettype wire

// File: rtl/apb_reg_bridge.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : apb_reg_bridge                                               |
// | Description : APB4 slave front-end that turns APB transfers into a simple  |
// |               register-bank strobe interface. Zero-wait writes, reads with |
// |               RD_LAT+1 wait states, PSLVERR on unmapped/misaligned or      |
// |               malformed (missed setup) accesses. All outputs registered.   |
// | Ports       : iPClk, iPRstn (async active-low)                             |
// |               iPSel, iPEnable, iPWrite, iPAddr[AW], iPWDat[DW],            |
// |               iPStrb[DW/8]                  APB request                    |
// |               oPRDat[DW], oPReady, oPSlvErr  APB response                  |
// |               oRegSel[NREG], oRegWr, oRegWD[DW], oRegStrb[DW/8]            |
// |                                             register-bank strobes          |
// |               iRegRD[DW]                    register-bank read data        |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module apb_reg_bridge
    import apb_bridge_pkg::*;
#(
    parameter int AW     = 8,
    parameter int DW     = 32,
    parameter int NREG   = 32,
    parameter int RD_LAT = 0
)
(
    input  logic                iPClk,
    input  logic                iPRstn,
    input  logic                iPSel,
    input  logic                iPEnable,
    input  logic                iPWrite,
    input  logic [AW-1:0]       iPAddr,
    input  logic [DW-1:0]       iPWDat,
    input  logic [DW/8-1:0]     iPStrb,
    output logic [DW-1:0]       oPRDat,
    output logic                oPReady,
    output logic                oPSlvErr,
    output logic [NREG-1:0]     oRegSel,
    output logic                oRegWr,
    output logic [DW-1:0]       oRegWD,
    output logic [DW/8-1:0]     oRegStrb,
    input  logic [DW-1:0]       iRegRD
);

    localparam int c_IW = AW - clog2(DW / 8);
    localparam int c_CW = clog2(RD_LAT_MAX + 1);

    bridgeState_t       r_state;
    logic [c_CW-1:0]    r_cnt;
    logic [DW-1:0]      r_pRDat;
    logic               r_pReady;
    logic               r_pSlvErr;
    logic [NREG-1:0]    r_regSel;
    logic               r_regWr;
    logic [DW-1:0]      r_regWD;
    logic [DW/8-1:0]    r_regStrb;

    logic [c_IW-1:0]    w_idx;
    logic [NREG-1:0]    w_sel;
    logic               w_valid;

    apb_addr_decode #(
        .AW   (AW),
        .DW   (DW),
        .NREG (NREG)
    ) u_decode (
        .iPAddr (iPAddr),
        .oIdx   (w_idx),
        .oSel   (w_sel),
        .oValid (w_valid)
    );

    // The word index is offered by the decoder for banks that want it; the
    // bridge itself only needs the one-hot form.
    logic w_unused;
    assign w_unused = ^w_idx;

    always_ff @(posedge iPClk or negedge iPRstn) begin
        if (!iPRstn) begin
            r_state   <= IDLE;
            r_cnt     <= '0;
            r_pRDat   <= '0;
            r_pReady  <= 1'b0;
            r_pSlvErr <= 1'b0;
            r_regSel  <= '0;
            r_regWr   <= 1'b0;
            r_regWD   <= '0;
            r_regStrb <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (iPSel) begin
                        // PENABLE already high means the setup phase was
                        // missed; answer with an error rather than guess.
                        if (iPEnable || !w_valid) begin
                            r_pReady  <= 1'b1;
                            r_pSlvErr <= 1'b1;
                            r_pRDat   <= '0;
                            r_state   <= RESP;
                        end else if (iPWrite) begin
                            // Outputs for T1 are loaded here so the write
                            // completes with zero wait states.
                            r_regSel  <= w_sel;
                            r_regWr   <= 1'b1;
                            r_regWD   <= iPWDat;
                            r_regStrb <= iPStrb;
                            r_pReady  <= 1'b1;
                            r_state   <= WR;
                        end else begin
                            r_regSel  <= w_sel;
                            r_cnt     <= c_CW'(RD_LAT);
                            r_state   <= RDWAIT;
                        end
                    end
                end

                WR: begin
                    r_regSel <= '0;
                    r_regWr  <= 1'b0;
                    r_pReady <= 1'b0;
                    r_state  <= IDLE;
                end

                RDWAIT: begin
                    if (!iPSel) begin
                        // Master abandoned the transfer: drop it silently.
                        r_regSel <= '0;
                        r_state  <= IDLE;
                    end else if (r_cnt == '0) begin
                        r_pRDat   <= iRegRD;
                        r_pReady  <= 1'b1;
                        r_pSlvErr <= 1'b0;
                        r_regSel  <= '0;
                        r_state   <= RESP;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end

                RESP: begin
                    r_pReady  <= 1'b0;
                    r_pSlvErr <= 1'b0;
                    r_state   <= IDLE;
                end

                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign oPRDat   = r_pRDat;
    assign oPReady  = r_pReady;
    assign oPSlvErr = r_pSlvErr;
    assign oRegSel  = r_regSel;
    assign oRegWr   = r_regWr;
    assign oRegWD   = r_regWD;
    assign oRegStrb = r_regStrb;

endmodule
`default_nettype wire

// File: tb/tb_apb_reg_bridge.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_apb_reg_bridge                                            |
// | Description : Directed self-checking bench for apb_reg_bridge. Four        |
// |               instances with RD_LAT = 0, 2, 3, 4 share the APB bus; PSEL   |
// |               is routed only to the instance under test.                   |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_apb_reg_bridge;

    localparam int NDUT = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                   rstn;
    logic                   selOn;
    int                     tgt;
    logic [NDUT-1:0]        pSel;
    logic                   pEnable;
    logic                   pWrite;
    logic [7:0]             pAddr;
    logic [31:0]            pWDat;
    logic [3:0]             pStrb;
    logic [31:0]            regRD;

    logic [NDUT-1:0][31:0]  pRDat;
    logic [NDUT-1:0]        pReady;
    logic [NDUT-1:0]        pSlvErr;
    logic [NDUT-1:0][31:0]  regSel;
    logic [NDUT-1:0]        regWr;
    logic [NDUT-1:0][31:0]  regWD;
    logic [NDUT-1:0][3:0]   regStrb;

    int checks   = 0;
    int failures = 0;

    always_comb begin
        pSel = '0;
        for (int k = 0; k < NDUT; k++) begin
            pSel[k] = selOn && (tgt == k);
        end
    end

    for (genvar k = 0; k < NDUT; k++) begin : g_dut
        apb_reg_bridge #(
            .AW     (8),
            .DW     (32),
            .NREG   (32),
            .RD_LAT ((k == 0) ? 0 : k + 1)
        ) u_dut (
            .iPClk    (clk),
            .iPRstn   (rstn),
            .iPSel    (pSel[k]),
            .iPEnable (pEnable),
            .iPWrite  (pWrite),
            .iPAddr   (pAddr),
            .iPWDat   (pWDat),
            .iPStrb   (pStrb),
            .oPRDat   (pRDat[k]),
            .oPReady  (pReady[k]),
            .oPSlvErr (pSlvErr[k]),
            .oRegSel  (regSel[k]),
            .oRegWr   (regWr[k]),
            .oRegWD   (regWD[k]),
            .oRegStrb (regStrb[k]),
            .iRegRD   (regRD)
        );
    end

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance to 1 ns after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drive a setup cycle, then move into the access cycle (T1).
    task automatic setup(input int t, input logic wr, input logic [7:0] addr,
                         input logic [31:0] wdat, input logic [3:0] strb);
        tgt     = t;
        selOn   = 1'b1;
        pEnable = 1'b0;
        pWrite  = wr;
        pAddr   = addr;
        pWDat   = wdat;
        pStrb   = strb;
        tick();
        pEnable = 1'b1;
    endtask

    task automatic idle();
        selOn   = 1'b0;
        pEnable = 1'b0;
    endtask

    initial begin
        rstn = 1'b0; selOn = 1'b0; tgt = 0; pEnable = 1'b0; pWrite = 1'b0;
        pAddr = '0; pWDat = '0; pStrb = '0; regRD = '0;
        tick(); tick();
        chk("rst_ready",  128'(pReady),  128'(0));
        chk("rst_err",    128'(pSlvErr), 128'(0));
        chk("rst_sel",    128'(regSel),  128'(0));
        chk("rst_wr",     128'(regWr),   128'(0));
        chk("rst_prdat",  128'(pRDat),   128'(0));
        rstn = 1'b1;
        tick();

        // Zero-wait write, inst RD_LAT=0
        setup(0, 1'b1, 8'h08, 32'hDEADBEEF, 4'hF);
        chk("wr_sel",   128'(regSel[0]),  128'(32'h4));
        chk("wr_pulse", 128'(regWr[0]),   128'(1));
        chk("wr_wd",    128'(regWD[0]),   128'(32'hDEADBEEF));
        chk("wr_strb",  128'(regStrb[0]), 128'(4'hF));
        chk("wr_ready", 128'(pReady[0]),  128'(1));
        chk("wr_err",   128'(pSlvErr[0]), 128'(0));
        tick(); idle();
        chk("wr_pulse_end", 128'(regWr[0]),  128'(0));
        chk("wr_ready_end", 128'(pReady[0]), 128'(0));
        chk("wr_sel_end",   128'(regSel[0]), 128'(0));

        // Read with RD_LAT=2: data valid only in T3, response in T4
        regRD = 32'hBAD0BAD0;
        setup(1, 1'b0, 8'h10, 32'h0, 4'hF);
        chk("rd_sel_t1", 128'(regSel[1]), 128'(32'h10));
        chk("rd_rdy_t1", 128'(pReady[1]), 128'(0));
        tick();
        chk("rd_sel_t2", 128'(regSel[1]), 128'(32'h10));
        chk("rd_rdy_t2", 128'(pReady[1]), 128'(0));
        tick(); regRD = 32'h12345678;
        chk("rd_sel_t3", 128'(regSel[1]), 128'(32'h10));
        chk("rd_rdy_t3", 128'(pReady[1]), 128'(0));
        tick(); regRD = 32'hBAD0BAD0;
        chk("rd_rdy_t4",   128'(pReady[1]),  128'(1));
        chk("rd_data_t4",  128'(pRDat[1]),   128'(32'h12345678));
        chk("rd_err_t4",   128'(pSlvErr[1]), 128'(0));
        chk("rd_sel_t4",   128'(regSel[1]),  128'(0));
        tick(); idle();
        chk("rd_rdy_t5",   128'(pReady[1]),  128'(0));
        chk("rd_hold_t5",  128'(pRDat[1]),   128'(32'h12345678));

        // Unmapped write, then misaligned read (back-to-back)
        setup(1, 1'b1, 8'h80, 32'h55, 4'hF);
        chk("unm_ready", 128'(pReady[1]),  128'(1));
        chk("unm_err",   128'(pSlvErr[1]), 128'(1));
        chk("unm_wr",    128'(regWr[1]),   128'(0));
        chk("unm_sel",   128'(regSel[1]),  128'(0));
        chk("unm_prdat", 128'(pRDat[1]),   128'(0));
        tick();
        chk("unm_wr_t2", 128'(regWr[1]),   128'(0));
        setup(1, 1'b0, 8'h06, 32'h0, 4'h0);
        chk("mis_ready", 128'(pReady[1]),  128'(1));
        chk("mis_err",   128'(pSlvErr[1]), 128'(1));
        chk("mis_prdat", 128'(pRDat[1]),   128'(0));
        chk("mis_sel",   128'(regSel[1]),  128'(0));
        tick(); idle();
        chk("mis_ready_end", 128'(pReady[1]),  128'(0));
        chk("mis_err_end",   128'(pSlvErr[1]), 128'(0));

        // Back-to-back write 0x00, read 0x04, write 0x7C on RD_LAT=0
        setup(0, 1'b1, 8'h00, 32'h11111111, 4'h3);
        chk("b2b_w0_sel",  128'(regSel[0]),  128'(32'h1));
        chk("b2b_w0_wr",   128'(regWr[0]),   128'(1));
        chk("b2b_w0_strb", 128'(regStrb[0]), 128'(4'h3));
        chk("b2b_w0_rdy",  128'(pReady[0]),  128'(1));
        tick();
        setup(0, 1'b0, 8'h04, 32'h0, 4'h0);
        chk("b2b_r_sel",  128'(regSel[0]), 128'(32'h2));
        chk("b2b_r_wr",   128'(regWr[0]),  128'(0));
        chk("b2b_r_rdy1", 128'(pReady[0]), 128'(0));
        regRD = 32'hCAFEF00D;
        tick(); regRD = 32'h0;
        chk("b2b_r_rdy",  128'(pReady[0]), 128'(1));
        chk("b2b_r_data", 128'(pRDat[0]),  128'(32'hCAFEF00D));
        chk("b2b_r_sel0", 128'(regSel[0]), 128'(0));
        tick();
        setup(0, 1'b1, 8'h7C, 32'hA5A5A5A5, 4'hC);
        chk("b2b_w2_sel",  128'(regSel[0]),  128'(32'h80000000));
        chk("b2b_w2_wr",   128'(regWr[0]),   128'(1));
        chk("b2b_w2_wd",   128'(regWD[0]),   128'(32'hA5A5A5A5));
        chk("b2b_w2_strb", 128'(regStrb[0]), 128'(4'hC));
        chk("b2b_w2_rdy",  128'(pReady[0]),  128'(1));
        tick(); idle();
        chk("b2b_w2_end",  128'(regWr[0]),   128'(0));

        // Write with PSTRB=0 still pulses; then a missed setup errors
        setup(0, 1'b1, 8'h04, 32'h0000FFFF, 4'h0);
        chk("zs_wr",   128'(regWr[0]),   128'(1));
        chk("zs_strb", 128'(regStrb[0]), 128'(4'h0));
        chk("zs_sel",  128'(regSel[0]),  128'(32'h2));
        tick();
        tgt = 0; selOn = 1'b1; pEnable = 1'b1; pWrite = 1'b1; pAddr = 8'h08;
        tick();
        chk("miss_rdy", 128'(pReady[0]),  128'(1));
        chk("miss_err", 128'(pSlvErr[0]), 128'(1));
        chk("miss_wr",  128'(regWr[0]),   128'(0));
        tick(); idle();
        chk("miss_rdy_end", 128'(pReady[0]), 128'(0));

        // PSEL dropped during RDWAIT, RD_LAT=4
        setup(3, 1'b0, 8'h0C, 32'h0, 4'h0);
        chk("ab_sel_t1", 128'(regSel[3]), 128'(32'h8));
        tick();
        chk("ab_sel_t2", 128'(regSel[3]), 128'(32'h8));
        idle();
        tick();
        chk("ab_sel_t3", 128'(regSel[3]), 128'(0));
        for (int i = 0; i < 4; i++) begin
            chk("ab_no_ready", 128'(pReady[3]), 128'(0));
            tick();
        end
        setup(3, 1'b1, 8'h14, 32'h600DCAFE, 4'hF);
        chk("ab_next_sel", 128'(regSel[3]), 128'(32'h20));
        chk("ab_next_wr",  128'(regWr[3]),  128'(1));
        chk("ab_next_rdy", 128'(pReady[3]), 128'(1));
        tick(); idle();

        // Reset mid-RDWAIT, RD_LAT=3
        setup(2, 1'b0, 8'h00, 32'h0, 4'h0);
        tick();
        chk("rm_sel_pre", 128'(regSel[2]), 128'(32'h1));
        rstn = 1'b0;
        #1;
        chk("rm_sel",   128'(regSel),  128'(0));
        chk("rm_ready", 128'(pReady),  128'(0));
        chk("rm_prdat", 128'(pRDat),   128'(0));
        chk("rm_wr",    128'(regWr),   128'(0));
        idle();
        tick(); tick();
        rstn = 1'b1;
        tick();
        regRD = 32'h5A5A1234;
        setup(2, 1'b0, 8'h08, 32'h0, 4'h0);
        chk("rm_rd_sel_t1", 128'(regSel[2]), 128'(32'h4));
        tick(); tick(); tick();
        chk("rm_rd_sel_t4", 128'(regSel[2]), 128'(32'h4));
        chk("rm_rd_rdy_t4", 128'(pReady[2]), 128'(0));
        tick();
        chk("rm_rd_rdy_t5",  128'(pReady[2]), 128'(1));
        chk("rm_rd_data_t5", 128'(pRDat[2]),  128'(32'h5A5A1234));
        tick(); idle();
        chk("rm_rd_end", 128'(pReady[2]), 128'(0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
